// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I pipeline control: opcodes, scoreboard
// entry layout, control FSM states and small decode helpers.
package rv32i_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_IW = 32'h00000013;

  // One in-flight destination register record.
  typedef struct packed {
    logic       valid;
    logic       wb;
    logic       is_load;
    logic [4:0] rd;
  } sb_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ctrl_state_t;

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) ||
           (op == OP_JALR) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    return (op != OP_STORE) && (op != OP_BRANCH);
  endfunction

endpackage

// File: rtl/rv32i_pipe_ctrl_hazard.sv
// Read-after-write hazard detection: decodes which source registers the
// ID instruction reads and compares them against the in-flight scoreboard.
import rv32i_pkg::*;

module rv32i_hazard_unit #(
  parameter bit FORWARD_EN = 1'b0
) (
  input  logic [6:0] opcode,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       id_valid,
  input  sb_entry_t  sb_ex,
  input  sb_entry_t  sb_mem,
  input  sb_entry_t  sb_wb,
  output logic       hazard
);

  logic use1;
  logic use2;
  logic m_ex;
  logic m_mem;
  logic m_wb;
  logic unused_sb;

  // The load flag only matters for the EX entry.
  assign unused_sb = sb_mem.is_load ^ sb_wb.is_load;

  // x0 is never a real dependency, so a zero source register never matches.
  function automatic logic entry_hit(input sb_entry_t e, input logic u1,
                                     input logic u2, input logic [4:0] r1,
                                     input logic [4:0] r2);
    return e.valid && e.wb &&
           ((u1 && (r1 != 5'd0) && (r1 == e.rd)) ||
            (u2 && (r2 != 5'd0) && (r2 == e.rd)));
  endfunction

  // Source usage decode and per-stage match, then forwarding-dependent select.
  always_comb begin
    use1   = uses_rs1(opcode);
    use2   = uses_rs2(opcode);
    m_ex   = entry_hit(sb_ex,  use1, use2, rs1, rs2);
    m_mem  = entry_hit(sb_mem, use1, use2, rs1, rs2);
    m_wb   = entry_hit(sb_wb,  use1, use2, rs1, rs2);
    hazard = id_valid && (FORWARD_EN ? (m_ex && sb_ex.is_load)
                                     : (m_ex || m_mem || m_wb));
  end

endmodule

// File: rtl/rv32i_pipe_ctrl.sv
// Central sequencer for the 5-stage RV32I pipe. Tracks in-flight
// destinations, stalls ID on RAW hazards, flushes IF/ID after redirects,
// freezes everything while data memory is busy, and counts stall/flush cycles.
//
// Handshake: there is no valid/ready pairing here; a stage register loads
// exactly on a cycle where its *_en is 1, and a *_flush of 1 on that cycle
// makes it load a NOP instead of its incoming data.
import rv32i_pkg::*;

module rv32i_pipe_ctrl #(
  parameter bit FORWARD_EN   = 1'b0,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_iw,
  input  logic             id_valid,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_flush,
  output logic             id_flush,
  output logic             id_stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_state_t state;
  logic [2:0]  flush_ctr;
  sb_entry_t   sb_ex;
  sb_entry_t   sb_mem;
  sb_entry_t   sb_wb;
  logic        hazard_raw;
  logic        hazard_act;
  logic        flush_any;
  logic        take_id;
  sb_entry_t   id_entry;
  logic        unused_iw;

  // funct3/funct7 carry no register-usage information.
  assign unused_iw = ^{id_iw[31:25], id_iw[14:12]};

  rv32i_hazard_unit #(
    .FORWARD_EN (FORWARD_EN)
  ) u_hazard (
    .opcode   (id_iw[6:0]),
    .rs1      (id_iw[19:15]),
    .rs2      (id_iw[24:20]),
    .id_valid (id_valid),
    .sb_ex    (sb_ex),
    .sb_mem   (sb_mem),
    .sb_wb    (sb_wb),
    .hazard   (hazard_raw)
  );

  // Redirect and flush outrank the hazard; the flushed ID instruction never issues.
  always_comb begin
    flush_any           = ex_redirect || (state == FLUSH);
    hazard_act          = hazard_raw && !flush_any;
    take_id             = id_valid && !flush_any && !hazard_act;
    id_entry            = '0;
    id_entry.valid      = take_id;
    id_entry.wb         = take_id && writes_rd(id_iw[6:0]);
    id_entry.is_load    = take_id && (id_iw[6:0] == OP_LOAD);
    id_entry.rd         = take_id ? id_iw[11:7] : 5'd0;
  end

  // Control outputs: reset > freeze > redirect/flush > hazard > run.
  always_comb begin
    pc_en     = 1'b1;
    if_id_en  = 1'b1;
    id_ex_en  = 1'b1;
    ex_mem_en = 1'b1;
    mem_wb_en = 1'b1;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    id_stall  = 1'b0;
    if (reset) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else if (mem_busy) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
    end else if (flush_any) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else if (hazard_act) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      id_flush = 1'b1;
      id_stall = 1'b1;
    end
  end

  // FSM, scoreboard shift and counters; everything holds while memory is busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      flush_ctr <= '0;
      sb_ex     <= '0;
      sb_mem    <= '0;
      sb_wb     <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!mem_busy) begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      sb_ex  <= id_entry;
      if (ex_redirect) begin
        if (FLUSH_CYCLES > 1) begin
          state     <= FLUSH;
          flush_ctr <= 3'(FLUSH_CYCLES - 1);
        end else begin
          state     <= RUN;
          flush_ctr <= '0;
        end
      end else if (state == FLUSH) begin
        if (flush_ctr <= 3'd1) begin
          state     <= RUN;
          flush_ctr <= '0;
        end else begin
          flush_ctr <= flush_ctr - 3'd1;
        end
      end
      if (id_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (if_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32i_pipe_ctrl.sv
// Directed bench for rv32i_pipe_ctrl. Two instances share stimulus:
// dut a (no forwarding, 2 flush cycles) and dut b (forwarding, 1 flush cycle).
module tb_rv32i_pipe_ctrl;

  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [31:0] ADDI5   = 32'h00100293; // addi x5,x0,1
  localparam logic [31:0] ADD655  = 32'h00528333; // add  x6,x5,x5
  localparam logic [31:0] LW5     = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] ADDI0   = 32'h00100013; // addi x0,x0,1
  localparam logic [31:0] ADD600  = 32'h00000333; // add  x6,x0,x0
  localparam logic [31:0] SW5     = 32'h0050A023; // sw   x5,0(x1)
  localparam logic [31:0] ADDI7   = 32'h00100393; // addi x7,x0,1
  localparam logic [31:0] ADDI8   = 32'h00100413; // addi x8,x0,1
  localparam logic [31:0] ADD978  = 32'h008384B3; // add  x9,x7,x8

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_flush, id_flush, id_stall}
  localparam logic [7:0] C_RUN    = 8'b11111_000;
  localparam logic [7:0] C_STALL  = 8'b00111_011;
  localparam logic [7:0] C_FLUSH  = 8'b11111_110;
  localparam logic [7:0] C_FREEZE = 8'b00000_000;
  localparam logic [7:0] C_RESET  = 8'b00000_110;

  logic        clk;
  logic        reset;
  logic [31:0] id_iw;
  logic        id_valid;
  logic        ex_redirect;
  logic        mem_busy;

  logic        a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en, a_mem_wb_en;
  logic        a_if_flush, a_id_flush, a_id_stall;
  logic [31:0] a_stall_cnt, a_flush_cnt;
  logic        b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en, b_mem_wb_en;
  logic        b_if_flush, b_id_flush, b_id_stall;
  logic [31:0] b_stall_cnt, b_flush_cnt;
  logic [7:0]  a_ctl, b_ctl;

  int checks = 0;
  int errors = 0;

  assign a_ctl = {a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en, a_mem_wb_en,
                  a_if_flush, a_id_flush, a_id_stall};
  assign b_ctl = {b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en, b_mem_wb_en,
                  b_if_flush, b_id_flush, b_id_stall};

  rv32i_pipe_ctrl #(.FORWARD_EN(1'b0), .FLUSH_CYCLES(2), .CNT_W(32)) u_dut_a (
    .clk(clk), .reset(reset), .id_iw(id_iw), .id_valid(id_valid),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_en(a_pc_en), .if_id_en(a_if_id_en), .id_ex_en(a_id_ex_en),
    .ex_mem_en(a_ex_mem_en), .mem_wb_en(a_mem_wb_en),
    .if_flush(a_if_flush), .id_flush(a_id_flush), .id_stall(a_id_stall),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  rv32i_pipe_ctrl #(.FORWARD_EN(1'b1), .FLUSH_CYCLES(1), .CNT_W(32)) u_dut_b (
    .clk(clk), .reset(reset), .id_iw(id_iw), .id_valid(id_valid),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_en(b_pc_en), .if_id_en(b_if_id_en), .id_ex_en(b_id_ex_en),
    .ex_mem_en(b_ex_mem_en), .mem_wb_en(b_mem_wb_en),
    .if_flush(b_if_flush), .id_flush(b_id_flush), .id_stall(b_id_stall),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of inputs and let combinational outputs settle.
  task automatic drive(input logic [31:0] iw, input logic v,
                       input logic redir, input logic busy);
    id_iw       = iw;
    id_valid    = v;
    ex_redirect = redir;
    mem_busy    = busy;
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(NOP, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(NOP, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check_eq("rst_ctl_a", 32'(a_ctl), 32'(C_RESET));
    check_eq("rst_ctl_b", 32'(b_ctl), 32'(C_RESET));
    check_eq("rst_stall_cnt", a_stall_cnt, 32'd0);
    check_eq("rst_flush_cnt", a_flush_cnt, 32'd0);
    reset = 1'b0;

    // RAW stall without forwarding: 3 stall cycles; dut b sees no load, no stall.
    drive(ADDI5, 1'b1, 1'b0, 1'b0);
    check_eq("raw_c0_a", 32'(a_ctl), 32'(C_RUN));
    tick();
    drive(ADD655, 1'b1, 1'b0, 1'b0);
    check_eq("raw_c1_a", 32'(a_ctl), 32'(C_STALL));
    check_eq("nonload_b", 32'(b_ctl), 32'(C_RUN));
    tick();
    check_eq("raw_c2_a", 32'(a_ctl), 32'(C_STALL));
    tick();
    check_eq("raw_c3_a", 32'(a_ctl), 32'(C_STALL));
    tick();
    check_eq("raw_c4_a", 32'(a_ctl), 32'(C_RUN));
    check_eq("raw_cnt_a", a_stall_cnt, 32'd3);
    check_eq("raw_cnt_b", b_stall_cnt, 32'd0);

    // Load-use with forwarding: exactly one stall.
    do_reset();
    drive(LW5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(ADD655, 1'b1, 1'b0, 1'b0);
    check_eq("lu_c1_b", 32'(b_ctl), 32'(C_STALL));
    tick();
    check_eq("lu_c2_b", 32'(b_ctl), 32'(C_RUN));
    check_eq("lu_cnt_b", b_stall_cnt, 32'd1);

    // x0 destinations and stores never create a dependency.
    do_reset();
    drive(ADDI0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(ADD600, 1'b1, 1'b0, 1'b0);
    check_eq("x0_a", 32'(a_ctl), 32'(C_RUN));
    tick();
    drive(SW5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(ADD655, 1'b1, 1'b0, 1'b0);
    check_eq("store_a", 32'(a_ctl), 32'(C_RUN));
    tick();
    check_eq("x0_store_cnt_a", a_stall_cnt, 32'd0);

    // Redirect: a flushes 2 cycles with the RAW in ID masked; b flushes 1.
    do_reset();
    drive(ADDI5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(ADD655, 1'b1, 1'b1, 1'b0);
    check_eq("redir_c1_a", 32'(a_ctl), 32'(C_FLUSH));
    check_eq("redir_c1_b", 32'(b_ctl), 32'(C_FLUSH));
    tick();
    drive(ADD655, 1'b1, 1'b0, 1'b0);
    check_eq("redir_c2_a", 32'(a_ctl), 32'(C_FLUSH));
    check_eq("redir_c2_b", 32'(b_ctl), 32'(C_RUN));
    tick();
    drive(NOP, 1'b1, 1'b0, 1'b0);
    check_eq("redir_c3_a", 32'(a_ctl), 32'(C_RUN));
    check_eq("redir_fcnt_a", a_flush_cnt, 32'd2);
    check_eq("redir_fcnt_b", b_flush_cnt, 32'd1);
    check_eq("redir_scnt_a", a_stall_cnt, 32'd0);

    // Freeze during a stall with a redirect pending behind it.
    do_reset();
    drive(ADDI5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(ADD655, 1'b1, 1'b0, 1'b0);
    check_eq("frz_stall_a", 32'(a_ctl), 32'(C_STALL));
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(ADD655, 1'b1, 1'b1, 1'b1);
      check_eq("frz_ctl_a", 32'(a_ctl), 32'(C_FREEZE));
      check_eq("frz_scnt_a", a_stall_cnt, 32'd1);
      check_eq("frz_fcnt_a", a_flush_cnt, 32'd0);
      tick();
    end
    drive(ADD655, 1'b1, 1'b1, 1'b0);
    check_eq("frz_redir_a", 32'(a_ctl), 32'(C_FLUSH));
    tick();
    drive(ADD655, 1'b1, 1'b0, 1'b0);
    check_eq("frz_flush2_a", 32'(a_ctl), 32'(C_FLUSH));
    tick();
    drive(NOP, 1'b1, 1'b0, 1'b0);
    check_eq("frz_after_a", 32'(a_ctl), 32'(C_RUN));
    check_eq("frz_fcnt_end_a", a_flush_cnt, 32'd2);

    // Freeze mid-stall without redirect: the stall resumes for the remaining 2 cycles.
    do_reset();
    drive(ADDI5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(ADD655, 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(ADD655, 1'b1, 1'b0, 1'b1);
      check_eq("hold_frz_a", 32'(a_ctl), 32'(C_FREEZE));
      tick();
    end
    drive(ADD655, 1'b1, 1'b0, 1'b0);
    check_eq("hold_s2_a", 32'(a_ctl), 32'(C_STALL));
    tick();
    check_eq("hold_s3_a", 32'(a_ctl), 32'(C_STALL));
    tick();
    check_eq("hold_run_a", 32'(a_ctl), 32'(C_RUN));
    check_eq("hold_cnt_a", a_stall_cnt, 32'd3);

    // Reset while flushing with a full scoreboard.
    do_reset();
    drive(ADDI5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(ADDI7, 1'b1, 1'b0, 1'b0);
    tick();
    drive(ADDI8, 1'b1, 1'b0, 1'b0);
    tick();
    drive(NOP, 1'b1, 1'b1, 1'b0);
    tick();
    reset = 1'b1;
    drive(ADD978, 1'b1, 1'b0, 1'b0);
    check_eq("mid_rst_ctl_a", 32'(a_ctl), 32'(C_RESET));
    tick();
    check_eq("mid_rst_ctl2_a", 32'(a_ctl), 32'(C_RESET));
    check_eq("mid_rst_fcnt_a", a_flush_cnt, 32'd0);
    check_eq("mid_rst_scnt_a", a_stall_cnt, 32'd0);
    reset = 1'b0;
    drive(ADD978, 1'b1, 1'b0, 1'b0);
    check_eq("post_rst_a", 32'(a_ctl), 32'(C_RUN));
    check_eq("post_rst_b", 32'(b_ctl), 32'(C_RUN));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Bound the whole run.
  initial begin
    #20000;
    errors++;
    $display("FAIL timeout got running exp finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_pipe_ctrl.md
Name: rv32i_pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RV32I core (IF, ID, EX, MEM, WB).
- Tracks destination registers in flight in EX/MEM/WB with a 3-entry scoreboard, and stalls ID on read-after-write hazards.
- Flushes IF/ID on taken branches/jumps and freezes the whole pipe while data memory is busy.
- Drives every stage-register enable and flush/bubble control; keeps saturating stall/flush performance counters.

Parameters:
- FORWARD_EN, 0: 0 = stall on any RAW match in EX/MEM/WB; 1 = EX/MEM forwarding exists, stall only on load-use (load in EX).
- FLUSH_CYCLES, 1: cycles IF/ID are flushed after a taken redirect (1..7).
- CNT_W, 32: width of performance counters.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- id_iw, in, 32: instruction word currently in ID.
- id_valid, in, 1: ID holds a real instruction.
- ex_redirect, in, 1: EX resolved a taken branch/JAL/JALR this cycle.
- mem_busy, in, 1: data-memory access in MEM not complete; hold pipe.
- pc_en, out, 1: PC register update enable.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en, out, 1 each: stage-register load enables.
- if_flush, id_flush, out, 1 each: load NOP (0x00000013) into IF/ID resp. ID/EX instead of incoming data.
- id_stall, out, 1: hazard stall active this cycle.
- stall_cnt, flush_cnt, out, CNT_W each: cycles spent in hazard stall / flush.

Behaviour:
- Reset (reset=1 at posedge): state<=RUN, flush_ctr<=0, scoreboard entries invalid, counters<=0. While reset is high, outputs are forced: all enables 0, if_flush=id_flush=1, id_stall=0.
- Decode of id_iw[6:0] (shared package):
  - uses rs1: 0110011, 0010011, 0000011, 1100111, 0100011, 1100011.
  - uses rs2: 0110011, 0100011, 1100011.
  - writes rd: all except 0100011 (store) and 1100011 (branch).
  - rd/rs fields: [11:7], [19:15], [24:20].
- Scoreboard entries {valid, wb, is_load, rd} for EX, MEM, WB. On an advance edge: WB<=MEM, MEM<=EX, EX<=ID info (or invalid if bubble/flush/!id_valid). On a freeze edge, hold all entries.
- Hazard, combinational: id_valid and a used rs != 0 matches rd of a valid wb entry.
  - FORWARD_EN=0: checks EX, MEM, WB entries.
  - FORWARD_EN=1: checks only an EX entry with is_load=1.
- Priority, evaluated each cycle: reset > freeze > redirect/flush > hazard > run.
  - Freeze (mem_busy=1): all enables 0, no flush, scoreboard and FSM hold. Counters hold. A simultaneous ex_redirect is ignored; EX must hold it until freeze ends.
  - Redirect (ex_redirect=1, state RUN): all enables 1, if_flush=id_flush=1, EX entry <= invalid. If FLUSH_CYCLES>1, state<=FLUSH with flush_ctr<=FLUSH_CYCLES-1.
  - FLUSH state: enables 1, if_flush=id_flush=1, flush_ctr decrements; return to RUN when flush_ctr reaches 0. A hazard in FLUSH is masked (the flushed instruction is discarded). ex_redirect in FLUSH is impossible by construction; if it occurs, reload flush_ctr.
  - Hazard (RUN, no redirect): pc_en=if_id_en=0, id_ex_en=1 with id_flush=1 (bubble into EX), ex_mem_en=mem_wb_en=1, id_stall=1. The scoreboard advances with an invalid EX entry, so the stall self-resolves in at most 3 cycles (FORWARD_EN=0) or 1 cycle (FORWARD_EN=1).
  - Run: all enables 1, no flush.
- Counters: stall_cnt +1 per hazard-stall cycle; flush_cnt +1 per cycle with if_flush=1 outside reset. Both saturate at all-ones.
- Latency: all control outputs are combinational from registered state and the current inputs (zero-cycle). State updates at the next posedge.
- Reset mid-flush or mid-stall: returns to RUN with an empty scoreboard the cycle after reset drops.

Decomposition:
- Shared package rv32i_pkg:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC) and NOP_IW=32'h00000013;
  - typedef sb_entry_t {valid, wb, is_load, rd[4:0]};
  - typedef enum ctrl_state_t {RUN, FLUSH}.
- One sub-module, rv32i_hazard_unit: combinational rs-use decode plus scoreboard comparison, producing the hazard signal. The FSM, scoreboard registers and counters stay in rv32i_pipe_ctrl.

Test Plan:
- RAW stall, FORWARD_EN=0: issue ADDI x5,x0,1 (0x00100293) then ADD x6,x5,x5 (0x00528333).
  - Required: id_stall=1 for exactly 3 cycles, pc_en=0 during them, stall_cnt=3; then ADD proceeds.
- Load-use, FORWARD_EN=1: LW x5,0(x1) (0x0000A283) then ADD x6,x5,x5.
  - Required: exactly 1 stall cycle, stall_cnt=1.
  - ADD behind a non-load: 0 stall cycles.
- x0 and store, FORWARD_EN=0:
  - ADDI x0,x0,1 then ADD x6,x0,x0 -> no stall.
  - SW x5,0(x1) then ADD x6,x5,x5 -> no stall from the store.
- Redirect, FLUSH_CYCLES=2: pulse ex_redirect for 1 cycle.
  - Required: if_flush=id_flush=1 for 2 consecutive cycles, then RUN; flush_cnt=2.
  - A RAW pattern present in ID during the flush raises no id_stall.
- Freeze: assert mem_busy for 4 cycles during a hazard stall, with ex_redirect also high.
  - Required: all enables 0 for 4 cycles, counters unchanged, scoreboard held.
  - After release, the pending redirect flushes and the stall resumes correctly.
- Reset mid-operation: assert reset during a FLUSH state with a full scoreboard.
  - Required: next cycle shows counters 0 and enables 0 with flushes 1.
  - First cycle after reset drops: enables 1, id_stall=0 for any instruction.
